des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//   DES round-key generator; sits directly downstream of the PC-1 permutation.
//   Accepts the 56-bit permuted key C0||D0 and emits the 16 48-bit round subkeys
//   one at a time, each after per-round C/D rotation and PC-2 compression.
//   Supports encrypt order (K1..K16) and decrypt order (K16..K1) over a valid/ready stream.
// PARAMETERS
//   none (DES widths are fixed: 56-bit key, 48-bit subkey, 16 rounds)
// PORTS
//   clk           in   1   single clock; all state updates on rising edge
//   rst           in   1   reset, synchronous, active-high
//   key_valid     in   1   key_in/decrypt valid
//   key_ready     out  1   block idle, can accept a key
//   key_in        in   56  PC-1 output; [55:28]=C0 (PC-1 bit 1 at [55]), [27:0]=D0
//   decrypt       in   1   sampled with key: 0 = K1..K16, 1 = K16..K1
//   subkey_valid  out  1   subkey/round valid
//   subkey_ready  in   1   consumer accepts subkey
//   subkey        out  48  current round key; [47] = PC-2 bit 1
//   round         out  4   logical round index 0..15 (0 = K1 in encrypt, 0 = K16 in decrypt)
//   subkey_last   out  1   high with the 16th subkey of a schedule
// BEHAVIOUR
//   - One clock domain; reset is synchronous and active-high.
//   - Reset values: key_ready=1, subkey_valid=0, subkey_last=0, round=0, subkey=0, cd_reg=0, state=IDLE.
//   - States: IDLE (key_ready=1, subkey_valid=0) -> RUN (key_ready=0, subkey_valid=1).
//   - IDLE: on key_valid&&key_ready at edge N: latch decrypt to mode_reg;
//     cd_reg <= first(key_in); round<=0; state<=RUN; subkey 1 valid after edge N (1-cycle latency).
//   - Shift table S[r], r=0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//   - Encrypt: first = rotl(S[0]); advance from round r: rotl(S[r+1]).
//     Decrypt: first = identity (C16D16==C0D0); advance from r: rotr(S[15-r]).
//   - Rotation is independent on C (28 b) and D (28 b), circular within each half.
//   - subkey = PC2(cd_reg), combinational from cd_reg; subkey[47-i] = cd_reg[56-P[i]],
//     P = 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2
//         41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
//   - RUN: subkey/round held stable while subkey_valid&&!subkey_ready (backpressure, any length).
//   - RUN handshake with round<15: apply advance rotation, round<=round+1.
//   - RUN handshake with round==15 (subkey_last=1): state<=IDLE; key_ready=1 the next cycle,
//     so back-to-back keys lose exactly one cycle. Round wraps to 0.
//   - key_valid while in RUN is ignored (not accepted, no effect).
//   - decrypt changing mid-schedule has no effect (mode_reg only).
//   - rst asserted mid-schedule: abort, all outputs to reset values next cycle; no partial subkeys resume.
//   - rst and key_valid same cycle: rst wins, key not accepted.
// CONFIGURATION
//   DES_KS_ZEROIZE_EN defined: on the final handshake cd_reg is cleared to 0, and subkey is
//     forced to 48'h0 whenever subkey_valid=0 (no key material visible when idle).
//   DES_KS_ZEROIZE_EN undefined: cd_reg retains C0D0 after completion; subkey shows
//     PC2(cd_reg) at all times (don't-care when subkey_valid=0).
// TESTING
//   1 Encrypt: key_in=56'hF0CCAAF556678F, decrypt=0, subkey_ready=1 -> round0 subkey=48'h1B02EFFC7072,
//     round15 subkey=48'hCB3D8B0E17F5 with subkey_last=1; 16 subkeys on 16 consecutive cycles.
//   2 Decrypt: same key, decrypt=1 -> first subkey 48'hCB3D8B0E17F5, last 48'h1B02EFFC7072,
//     full sequence equals scenario 1 reversed.
//   3 Backpressure: scenario 1 with subkey_ready low 3 cycles at round 5 -> subkey and round
//     stable across stall; sequence unchanged; key_valid pulsed during RUN is not accepted.
//   4 Reset mid-run: rst at round 7 -> next cycle subkey_valid=0, key_ready=1, round=0;
//     new key after reset yields correct full schedule from K1.
//   5 Back-to-back: second key held valid -> accepted the cycle after subkey_last handshake;
//     exactly one idle cycle between schedules; all 32 subkeys match the golden model.
//   6 Zeroize: with DES_KS_ZEROIZE_EN, after final handshake subkey==0 and cd_reg==0 while idle;
//     without it, subkey==PC2(C0D0) while idle.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out stream bundle for the DES round-key generator.
// master drives keys and accepts subkeys; slave is the key schedule itself.
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [55:0] key_in;
  logic        decrypt;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        subkey_last;

  modport master (
    output key_valid, key_in, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round, subkey_last
  );

  modport slave (
    input  key_valid, key_in, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round, subkey_last
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES round-key generator: takes PC-1 output C0||D0, streams K1..K16 (or K16..K1).
// Optional DES_KS_ZEROIZE_EN: clear key state after the last subkey and blank subkey when idle.
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rst,
  des_key_schedule_if.slave    ks
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q, state_d;
  logic        mode_q,  mode_d;
  logic [55:0] cd_q,    cd_d;
  logic [3:0]  round_q, round_d;

  // Per-round left-shift amounts; rounds 1, 2, 9 and 16 shift by one.
  function automatic logic [1:0] shamt(input logic [3:0] r);
    return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic left);
    logic [27:0] y;
    if (left) y = (n == 2'd1) ? {x[26:0], x[27]}    : {x[25:0], x[27:26]};
    else      y = (n == 2'd1) ? {x[0],    x[27:1]}  : {x[1:0],  x[27:2]};
    return y;
  endfunction

  function automatic logic [55:0] rot56(input logic [55:0] cd, input logic [1:0] n,
                                        input logic left);
    return {rot28(cd[55:28], n, left), rot28(cd[27:0], n, left)};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_TAB[i]];
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cd_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cd_q    <= cd_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cd_d    = cd_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (ks.key_valid) begin
          mode_d  = ks.decrypt;
          // Decrypt starts at C16D16, which equals C0D0 after the full 28-bit rotation.
          cd_d    = ks.decrypt ? ks.key_in : rot56(ks.key_in, shamt(4'd0), 1'b1);
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ks.subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            round_d = '0;
`ifdef DES_KS_ZEROIZE_EN
            cd_d    = '0;
`else
            // Decrypt ends on C1D1; one more right shift leaves C0D0 in both modes.
            cd_d    = mode_q ? rot56(cd_q, shamt(4'd0), 1'b0) : cd_q;
`endif
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = mode_q ? rot56(cd_q, shamt(4'd15 - round_q), 1'b0)
                             : rot56(cd_q, shamt(round_q + 4'd1), 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ks.key_ready    = (state_q == IDLE);
    ks.subkey_valid = (state_q == RUN);
    ks.round        = round_q;
    ks.subkey_last  = (state_q == RUN) && (round_q == 4'd15);
`ifdef DES_KS_ZEROIZE_EN
    ks.subkey       = (state_q == RUN) ? pc2(cd_q) : 48'h0;
`else
    ks.subkey       = pc2(cd_q);
`endif
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key schedule.
module tb_des_key_schedule;

  localparam logic [55:0] KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] GOLD [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
`ifdef DES_KS_ZEROIZE_EN
  localparam logic [47:0] IDLE_KEY = 48'h0;
`else
  localparam logic [47:0] IDLE_KEY = 48'hCB3D8B0E17F5;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  des_key_schedule_if ks_if ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input bit dec);
    chk("kready_pre", ks_if.key_ready, 1);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = KEY;
    ks_if.decrypt   = dec;
    @(negedge clk);
    ks_if.key_valid = 1'b0;
    ks_if.decrypt   = ~dec;
  endtask

  // Walks one schedule from round 0; optional stall (with a stray key pulse) and abort.
  task automatic drain(input bit dec, input int stall_at, input int stall_len, input int abort_at);
    logic [47:0] e;
    for (int r = 0; r < 16; r++) begin
      e = dec ? GOLD[15-r] : GOLD[r];
      if (r == stall_at) begin
        ks_if.subkey_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_key", ks_if.subkey, e);
          chk("stall_rnd", ks_if.round, r);
          ks_if.key_valid = (s == stall_len - 1);
          ks_if.key_in    = 56'h0123456789ABCD;
          @(negedge clk);
        end
        ks_if.key_valid    = 1'b0;
        ks_if.key_in       = KEY;
        ks_if.subkey_ready = 1'b1;
      end
      chk("subkey", ks_if.subkey, e);
      chk("round", ks_if.round, r);
      chk("valid", ks_if.subkey_valid, 1);
      chk("last", ks_if.subkey_last, (r == 15));
      chk("kready_run", ks_if.key_ready, 0);
      if (r == abort_at) begin
        rst = 1'b1;
        ks_if.key_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ks_if.key_valid = 1'b0;
        chk("rst_valid", ks_if.subkey_valid, 0);
        chk("rst_kready", ks_if.key_ready, 1);
        chk("rst_round", ks_if.round, 0);
        chk("rst_last", ks_if.subkey_last, 0);
        chk("rst_subkey", ks_if.subkey, 0);
        return;
      end
      @(negedge clk);
    end
    chk("idle_kready", ks_if.key_ready, 1);
    chk("idle_valid", ks_if.subkey_valid, 0);
    chk("idle_last", ks_if.subkey_last, 0);
    chk("idle_subkey", ks_if.subkey, IDLE_KEY);
  endtask

  initial begin
    rst                = 1'b1;
    ks_if.key_valid    = 1'b1;
    ks_if.key_in       = KEY;
    ks_if.decrypt      = 1'b0;
    ks_if.subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    ks_if.key_valid = 1'b0;
    chk("reset_kready", ks_if.key_ready, 1);
    chk("reset_valid", ks_if.subkey_valid, 0);
    chk("reset_last", ks_if.subkey_last, 0);
    chk("reset_round", ks_if.round, 0);
    chk("reset_subkey", ks_if.subkey, 0);
    rst = 1'b0;

    // encrypt, decrypt, encrypt with stall
    load(1'b0); drain(1'b0, -1, 0, -1);
    load(1'b1); drain(1'b1, -1, 0, -1);
    load(1'b0); drain(1'b0, 5, 3, -1);

    // abort at round 7, then a clean schedule
    load(1'b0); drain(1'b0, -1, 0, 7);
    load(1'b0); drain(1'b0, -1, 0, -1);

    // back-to-back: key held valid across the first schedule
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = KEY;
    ks_if.decrypt   = 1'b0;
    @(negedge clk);
    ks_if.decrypt   = 1'b1;
    drain(1'b0, -1, 0, -1);
    @(negedge clk);
    ks_if.key_valid = 1'b0;
    ks_if.decrypt   = 1'b0;
    drain(1'b1, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
